registers_bank: RTL and testbench

REGISTERS_BANK -- requirements
Module: registers_bank

---
 rtl/regbank_pkg.sv | 12 +
 rtl/regbank_read_port.sv | 48 ++++
 rtl/registers_bank.sv | 103 ++++++++++
 tb/tb_registers_bank.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared constants and index type for the register bank.
package regbank_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int SP_INDEX_DEF = 29;
    localparam int SP_RESET_DEF = 227;
    localparam int IDX_W        = 5;

    typedef logic [IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/regbank_read_port.sv
// One registered read port of the bank, with optional write-to-read bypass.
// Bypass enabled by defining REGISTERS_BANK_BYPASS_EN.
module regbank_read_port
    import regbank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  reg_idx_t          rd_idx,
    input  logic [DATA_W-1:0] rd_val,
    input  logic              wr_en,
    input  reg_idx_t          wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

`ifdef REGISTERS_BANK_BYPASS_EN
    always_comb begin
        rd_data_d = rd_val;
        // x0 is hardwired, so it must never pick up in-flight data
        if (wr_en && (wr_idx == rd_idx) && (rd_idx != '0)) begin
            rd_data_d = wr_data;
        end
    end
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_idx, wr_data};

    always_comb begin
        rd_data_d = rd_val;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/registers_bank.sv
// Architectural register file: two registered read ports, one write port.
// Define REGISTERS_BANK_BYPASS_EN to forward same-edge writes to reads.
module registers_bank
    import regbank_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int SP_INDEX = SP_INDEX_DEF,
    parameter int SP_RESET = SP_RESET_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [4:0]        write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [4:0]        read_reg_1,
    input  logic [4:0]        read_reg_2,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    output logic              write_ack
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              write_ack_d;
    logic              write_ack_q;
    logic              wr_commit;
    logic [DATA_W-1:0] rd_val_1;
    logic [DATA_W-1:0] rd_val_2;

    assign wr_commit = reg_write
                     && (write_reg != '0)
                     && (int'(write_reg) < NUM_REGS);

    always_comb begin
        regs_d = regs_q;
        if (wr_commit) begin
            regs_d[write_reg] = write_data;
        end
    end

    always_comb begin
        write_ack_d = wr_commit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == SP_INDEX) ? DATA_W'(SP_RESET) : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_ack_q <= 1'b0;
        end else begin
            write_ack_q <= write_ack_d;
        end
    end

    always_comb begin
        rd_val_1 = '0;
        rd_val_2 = '0;
        if (int'(read_reg_1) < NUM_REGS) begin
            rd_val_1 = regs_q[read_reg_1];
        end
        if (int'(read_reg_2) < NUM_REGS) begin
            rd_val_2 = regs_q[read_reg_2];
        end
    end

    regbank_read_port #(
        .DATA_W (DATA_W)
    ) u_rd_1 (
        .clk     (clk),
        .reset   (reset),
        .rd_idx  (read_reg_1),
        .rd_val  (rd_val_1),
        .wr_en   (wr_commit),
        .wr_idx  (write_reg),
        .wr_data (write_data),
        .rd_data (read_data_1)
    );

    regbank_read_port #(
        .DATA_W (DATA_W)
    ) u_rd_2 (
        .clk     (clk),
        .reset   (reset),
        .rd_idx  (read_reg_2),
        .rd_val  (rd_val_2),
        .wr_en   (wr_commit),
        .wr_idx  (write_reg),
        .wr_data (write_data),
        .rd_data (read_data_2)
    );

    assign write_ack = write_ack_q;

endmodule

// File: tb/tb_registers_bank.sv
// Scoreboard bench for registers_bank; expectations come from a reference model.
module tb_registers_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reg_write = 1'b0;
    logic [4:0]  write_reg = '0;
    logic [31:0] write_data = '0;
    logic [4:0]  read_reg_1 = '0;
    logic [4:0]  read_reg_2 = '0;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic        write_ack;

    always #5 clk = ~clk;

    registers_bank dut (
        .clk         (clk),
        .reset       (reset),
        .reg_write   (reg_write),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .read_reg_1  (read_reg_1),
        .read_reg_2  (read_reg_2),
        .read_data_1 (read_data_1),
        .read_data_2 (read_data_2),
        .write_ack   (write_ack)
    );

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic        ack;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
    } stim_t;

`ifdef REGISTERS_BANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    exp_t        sb[$];
    logic [31:0] mdl [32];
    int          checks = 0;
    int          errors = 0;

    task automatic drive(input stim_t s);
        exp_t e;
        logic commit;
        reset      = s.rst;
        reg_write  = s.we;
        write_reg  = s.wa;
        write_data = s.wd;
        read_reg_1 = s.r1;
        read_reg_2 = s.r2;
        commit = !s.rst && s.we && (s.wa != 5'd0);
        if (s.rst) begin
            e.d1 = '0;
            e.d2 = '0;
        end else begin
            e.d1 = (BYP && commit && s.r1 == s.wa) ? s.wd : mdl[s.r1];
            e.d2 = (BYP && commit && s.r2 == s.wa) ? s.wd : mdl[s.r2];
        end
        e.ack = commit;
        if (s.rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = (i == 29) ? 32'd227 : 32'd0;
        end else if (commit) begin
            mdl[s.wa] = s.wd;
        end
        sb.push_back(e);
    endtask

    function automatic stim_t mk(input logic rst, input logic we,
                                 input logic [4:0] wa, input logic [31:0] wd,
                                 input logic [4:0] r1, input logic [4:0] r2);
        stim_t s;
        s.rst = rst; s.we = we; s.wa = wa; s.wd = wd; s.r1 = r1; s.r2 = r2;
        return s;
    endfunction

    task automatic test_reset;
        stim_t st[$];
        exp_t  e;
        st.push_back(mk(1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 32; i++) st.push_back(mk(0, 0, 0, 0, 5'(i), 5'(31 - i)));
        foreach (st[i]) begin
            drive(st[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            if (read_data_1 !== e.d1) begin
                errors++; $display("FAIL reset[%0d] read_data_1 got %h exp %h", i, read_data_1, e.d1);
            end
            if (read_data_2 !== e.d2) begin
                errors++; $display("FAIL reset[%0d] read_data_2 got %h exp %h", i, read_data_2, e.d2);
            end
            if (write_ack !== e.ack) begin
                errors++; $display("FAIL reset[%0d] write_ack got %b exp %b", i, write_ack, e.ack);
            end
        end
    endtask

    task automatic test_write_read;
        stim_t st[$];
        exp_t  e;
        st.push_back(mk(0, 1, 8, 32'hDEADBEEF, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 8, 8));
        st.push_back(mk(0, 0, 0, 0, 8, 29));
        foreach (st[i]) begin
            drive(st[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            if (read_data_1 !== e.d1) begin
                errors++; $display("FAIL wr_rd[%0d] read_data_1 got %h exp %h", i, read_data_1, e.d1);
            end
            if (read_data_2 !== e.d2) begin
                errors++; $display("FAIL wr_rd[%0d] read_data_2 got %h exp %h", i, read_data_2, e.d2);
            end
            if (write_ack !== e.ack) begin
                errors++; $display("FAIL wr_rd[%0d] write_ack got %b exp %b", i, write_ack, e.ack);
            end
        end
    endtask

    task automatic test_reg0;
        stim_t st[$];
        exp_t  e;
        st.push_back(mk(0, 1, 0, 32'h12345678, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            drive(st[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            if (read_data_1 !== e.d1) begin
                errors++; $display("FAIL reg0[%0d] read_data_1 got %h exp %h", i, read_data_1, e.d1);
            end
            if (read_data_2 !== e.d2) begin
                errors++; $display("FAIL reg0[%0d] read_data_2 got %h exp %h", i, read_data_2, e.d2);
            end
            if (write_ack !== e.ack) begin
                errors++; $display("FAIL reg0[%0d] write_ack got %b exp %b", i, write_ack, e.ack);
            end
        end
    endtask

    task automatic test_same_edge;
        stim_t st[$];
        exp_t  e;
        st.push_back(mk(0, 1, 5, 32'h11, 0, 0));
        st.push_back(mk(0, 1, 5, 32'h22, 5, 0));
        st.push_back(mk(0, 0, 0, 0, 5, 5));
        foreach (st[i]) begin
            drive(st[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            if (read_data_1 !== e.d1) begin
                errors++; $display("FAIL same_edge[%0d] read_data_1 got %h exp %h", i, read_data_1, e.d1);
            end
            if (read_data_2 !== e.d2) begin
                errors++; $display("FAIL same_edge[%0d] read_data_2 got %h exp %h", i, read_data_2, e.d2);
            end
            if (write_ack !== e.ack) begin
                errors++; $display("FAIL same_edge[%0d] write_ack got %b exp %b", i, write_ack, e.ack);
            end
        end
    endtask

    task automatic test_reset_priority;
        stim_t st[$];
        exp_t  e;
        st.push_back(mk(0, 1, 10, 32'h77, 0, 0));
        st.push_back(mk(1, 1, 29, 32'h55, 29, 10));
        st.push_back(mk(0, 0, 0, 0, 29, 10));
        st.push_back(mk(0, 0, 0, 0, 8, 5));
        foreach (st[i]) begin
            drive(st[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            if (read_data_1 !== e.d1) begin
                errors++; $display("FAIL rst_prio[%0d] read_data_1 got %h exp %h", i, read_data_1, e.d1);
            end
            if (read_data_2 !== e.d2) begin
                errors++; $display("FAIL rst_prio[%0d] read_data_2 got %h exp %h", i, read_data_2, e.d2);
            end
            if (write_ack !== e.ack) begin
                errors++; $display("FAIL rst_prio[%0d] write_ack got %b exp %b", i, write_ack, e.ack);
            end
        end
    endtask

    task automatic test_back_to_back;
        stim_t st[$];
        exp_t  e;
        st.push_back(mk(0, 1, 3, 32'hA, 3, 3));
        st.push_back(mk(0, 1, 3, 32'hB, 3, 3));
        st.push_back(mk(0, 1, 3, 32'hC, 3, 3));
        st.push_back(mk(0, 0, 0, 0, 3, 3));
        st.push_back(mk(0, 0, 0, 0, 3, 3));
        foreach (st[i]) begin
            drive(st[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            if (read_data_1 !== e.d1) begin
                errors++; $display("FAIL b2b[%0d] read_data_1 got %h exp %h", i, read_data_1, e.d1);
            end
            if (read_data_2 !== e.d2) begin
                errors++; $display("FAIL b2b[%0d] read_data_2 got %h exp %h", i, read_data_2, e.d2);
            end
            if (write_ack !== e.ack) begin
                errors++; $display("FAIL b2b[%0d] write_ack got %b exp %b", i, write_ack, e.ack);
            end
        end
    endtask

    task automatic test_random;
        stim_t st[$];
        exp_t  e;
        for (int i = 0; i < 60; i++) begin
            st.push_back(mk(($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)),
                            5'($urandom_range(0, 7)), $urandom,
                            5'($urandom_range(0, 7)), 5'($urandom_range(0, 31))));
        end
        foreach (st[i]) begin
            drive(st[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            if (read_data_1 !== e.d1) begin
                errors++; $display("FAIL rand[%0d] read_data_1 got %h exp %h", i, read_data_1, e.d1);
            end
            if (read_data_2 !== e.d2) begin
                errors++; $display("FAIL rand[%0d] read_data_2 got %h exp %h", i, read_data_2, e.d2);
            end
            if (write_ack !== e.ack) begin
                errors++; $display("FAIL rand[%0d] write_ack got %b exp %b", i, write_ack, e.ack);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        @(posedge clk); #1;
        test_reset();
        test_write_read();
        test_reg0();
        test_same_edge();
        test_reset_priority();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
